// File: rtl/ysyx_23060240_csr_ctrl.sv
// rtl/ysyx_23060240_csr_ctrl.sv - Zicsr/ecall/mret sequencer driving the CSR-file port
// Optional: `define CSR_CTRL_ILLEGAL_ADDR_EN restricts legal CSR numbers to mstatus/mtvec/mepc/mcause.
module ysyx_23060240_csr_ctrl #(
  parameter int XLEN       = 32,
  parameter bit TVEC_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic            is_csr,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      rs1_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rd_idx,
  input  logic [XLEN-1:0] pc,
  output logic [11:0]     r_csr_addr,
  output logic            r_csr_en,
  input  logic [XLEN-1:0] r_csr_data,
  output logic [11:0]     w_csr_addr,
  output logic [XLEN-1:0] w_csr_data,
  output logic            w_csr_en,
  output logic            finish,
  output logic            jump_ecall,
  output logic            jump_mret,
  output logic [XLEN-1:0] csr_pc,
  output logic            done,
  output logic            rd_we,
  output logic [XLEN-1:0] rd_data,
  output logic            redirect,
  output logic [XLEN-1:0] next_pc,
  output logic            illegal
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, DONE} state_t;

  state_t          state, state_nx;
  logic [2:0]      f3_q;
  logic [11:0]     addr_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [4:0]      rd_idx_q;
  logic [XLEN-1:0] pc_q;
  logic            ecall_q, mret_q, illegal_q;
  logic [XLEN-1:0] old_q, next_pc_q;

  logic            accept, any_class, addr_ok, illegal_in, trap_q, we;
  logic [XLEN-1:0] src, new_val;

`ifdef CSR_CTRL_ILLEGAL_ADDR_EN
  assign addr_ok = (csr_addr == 12'h300) || (csr_addr == 12'h305) ||
                   (csr_addr == 12'h341) || (csr_addr == 12'h342);
`else
  assign addr_ok = 1'b1;
`endif

  assign accept     = inst_valid && (state == IDLE);
  assign any_class  = is_csr || is_ecall || is_mret;
  assign illegal_in = !is_ecall && !is_mret && ((funct3[1:0] == 2'b00) || !addr_ok);
  assign trap_q     = ecall_q || mret_q;

  // Read-modify-write operand: register value or zero-extended zimm field.
  assign src = f3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

  always_comb begin
    new_val = src;
    we      = 1'b1;
    case (f3_q[1:0])
      2'b10:   begin new_val = old_q | src;  we = (rs1_idx_q != 5'd0); end
      2'b11:   begin new_val = old_q & ~src; we = (rs1_idx_q != 5'd0); end
      default: begin new_val = src;          we = 1'b1;                end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      f3_q       <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      pc_q       <= '0;
      ecall_q    <= 1'b0;
      mret_q     <= 1'b0;
      illegal_q  <= 1'b0;
      old_q      <= '0;
      next_pc_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept && any_class) begin
        f3_q       <= funct3;
        addr_q     <= csr_addr;
        rs1_idx_q  <= rs1_idx;
        rs1_data_q <= rs1_data;
        rd_idx_q   <= rd_idx;
        pc_q       <= pc;
        ecall_q    <= is_ecall;
        mret_q     <= is_mret && !is_ecall;
        illegal_q  <= illegal_in;
        old_q      <= '0;
        next_pc_q  <= '0;
      end
      if (state == READ) old_q <= r_csr_data;
      // The CSR file presents mtvec (ecall) or mepc (mret) while the strobe is high.
      if (state == TRAP)
        next_pc_q <= (ecall_q && TVEC_ALIGN) ? {r_csr_data[XLEN-1:2], 2'b00} : r_csr_data;
    end
  end

  always_comb begin
    state_nx   = state;
    r_csr_addr = '0;
    r_csr_en   = 1'b0;
    w_csr_addr = '0;
    w_csr_data = '0;
    w_csr_en   = 1'b0;
    finish     = 1'b0;
    jump_ecall = 1'b0;
    jump_mret  = 1'b0;
    csr_pc     = '0;
    case (state)
      IDLE: begin
        if (accept && any_class) begin
          if (is_ecall || is_mret) state_nx = TRAP;
          else if (illegal_in)     state_nx = DONE;
          else                     state_nx = READ;
        end
      end
      READ: begin
        r_csr_addr = addr_q;
        r_csr_en   = 1'b1;
        finish     = 1'b1;
        state_nx   = WRITE;
      end
      WRITE: begin
        w_csr_addr = addr_q;
        w_csr_data = new_val;
        w_csr_en   = we;
        finish     = 1'b1;
        state_nx   = DONE;
      end
      TRAP: begin
        jump_ecall = ecall_q;
        jump_mret  = mret_q;
        csr_pc     = pc_q;
        state_nx   = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign inst_ready = (state == IDLE);
  assign done       = (state == DONE);
  assign rd_we      = done && !illegal_q && !trap_q && (rd_idx_q != 5'd0);
  assign rd_data    = old_q;
  assign redirect   = done && trap_q;
  assign next_pc    = next_pc_q;
  assign illegal    = done && illegal_q;

endmodule

// File: doc/ysyx_23060240_csr_ctrl.md
Name: ysyx_23060240_csr_ctrl

Overview:
- Initiator side of the CSR-file port. Accepts one decoded Zicsr/ecall/mret instruction from the EXU and sequences the CSR read, modify and write cycles.
- Drives the trap strobes `jump_ecall` / `jump_mret` and returns the rd value and the redirect PC to the core.
- Sits between the decode/execute stage and the CSR register file, and owns every CSR-file control input.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TVEC_ALIGN, 1, when 1 the ecall redirect target is mtvec with bits[1:0] forced to 0; when 0 the raw mtvec is used.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  block idle, can accept
- is_csr  in  1  Zicsr instruction
- is_ecall  in  1  ecall instruction
- is_mret  in  1  mret instruction
- funct3  in  3  Zicsr funct3
- csr_addr  in  12  CSR number
- rs1_idx  in  5  rs1 index (also the zimm field)
- rs1_data  in  32  rs1 value
- rd_idx  in  5  destination index
- pc  in  32  PC of the instruction
- r_csr_addr  out  12  CSR read address
- r_csr_en  out  1  CSR read enable
- r_csr_data  in  32  CSR read data, combinational
- w_csr_addr  out  12  CSR write address
- w_csr_data  out  32  CSR write data
- w_csr_en  out  1  CSR write enable
- finish  out  1  CSR access qualifier
- jump_ecall  out  1  ecall strobe to the CSR file
- jump_mret  out  1  mret strobe to the CSR file
- csr_pc  out  32  PC presented to the CSR file (mepc source)
- done  out  1  one-cycle completion pulse
- rd_we  out  1  write rd, valid with done
- rd_data  out  32  old CSR value, valid with done
- redirect  out  1  next_pc valid, with done
- next_pc  out  32  trap/return target
- illegal  out  1  illegal access, with done

Behaviour:
- States: IDLE, READ, WRITE, TRAP, DONE.
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE; all registered outputs and captured fields clear to 0.
  - Reset mid-operation abandons the instruction; no CSR write or strobe is issued on or after the reset edge.
- inst_ready = (state==IDLE). Accept = inst_valid & inst_ready.
  - At accept, capture funct3, csr_addr, rs1_idx, rs1_data, rd_idx and pc.
  - Accept with none of is_csr/is_ecall/is_mret set: ignored, stay in IDLE.
- Priority when several class bits are set: is_ecall > is_mret > is_csr.
- CSR path, IDLE -> READ -> WRITE -> DONE -> IDLE:
  - READ: r_csr_en=1, finish=1, r_csr_addr=csr_addr. Register old = r_csr_data.
  - WRITE: w_csr_addr=csr_addr, w_csr_data=new, w_csr_en=we, finish=1.
  - Operand src = rs1_data for funct3[2]=0, else zero-extended rs1_idx.
  - funct3[1:0]=01 (RW): new=src, we=1.
  - funct3[1:0]=10 (RS): new=old|src, we=(rs1_idx!=0).
  - funct3[1:0]=11 (RC): new=old&~src, we=(rs1_idx!=0).
  - funct3 000 or 100: skip READ/WRITE, go straight to DONE with illegal=1, rd_we=0.
  - DONE: done=1, rd_data=old, rd_we=(rd_idx!=0), redirect=0.
  - Latency: done is high 3 cycles after the accept edge.
- ecall path, IDLE -> TRAP -> DONE:
  - TRAP: jump_ecall=1, csr_pc=pc, r_csr_en=0, w_csr_en=0, finish=0.
  - Register next_pc = r_csr_data (mtvec), aligned per TVEC_ALIGN.
  - The CSR file latches mepc=pc and mcause=0xb on this edge.
  - DONE: done=1, redirect=1, rd_we=0.
- mret path: same as ecall with jump_mret=1 and next_pc = r_csr_data (mepc), never aligned.
- In TRAP, jump_ecall and jump_mret are never both high.
- Outside the state named above, every CSR control output is 0.
- done is a single-cycle pulse.
- inst_valid held during a busy period is not re-accepted until the cycle after DONE (IDLE).

Optional Feature:
- Macro CSR_CTRL_ILLEGAL_ADDR_EN.
- Defined: csr_addr not in {0x300, 0x305, 0x341, 0x342} takes the illegal path (no READ/WRITE, illegal=1, rd_we=0).
- Undefined: any address is sequenced normally and illegal is asserted only for funct3 000/100.

Test Plan:
- Reset in the middle of READ -> next cycle state IDLE, w_csr_en stays 0, done=0, inst_ready=1.
- CSRRW 0x305, rs1_data=0x80000100, rd=5 -> WRITE cycle w_csr_en=1, w_csr_data=0x80000100; done at +3 with rd_we=1, rd_data=prior mtvec (0x0 after CSR init).
- CSRRS 0x300 with rs1=x0, rd=7 -> READ only, w_csr_en=0 throughout; rd_data=0x1800, rd_we=1.
- CSRRCI 0x341, zimm=3, old mepc=0x8000000F -> w_csr_data=0x8000000C.
- mtvec=0x80000103, ecall at pc=0x80000200 -> jump_ecall high for 1 cycle; next_pc=0x80000100 with TVEC_ALIGN=1; subsequent CSRRS read of 0x341 returns 0x80000200.
- is_ecall and is_mret both set -> only jump_ecall pulses. Then mret -> next_pc=0x80000200, redirect=1.
